// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the expansion-SRAM access arbiter.
package sram_arb_pkg;

  localparam int ADDR_W_DEF   = 20;
  // Byte-address bit that selects chip 1 (ramcs1_b) over chip 0 (ramcs0_b).
  localparam int CHIP_SEL_BIT = 19;

  typedef enum logic [2:0] {
    IDLE,
    CPU,
    AUX_SETUP,
    AUX_STROBE,
    AUX_DONE
  } arb_state_e;

  // True while the arbiter is working on an aux transfer.
  function automatic logic is_aux_state(input arb_state_e s);
    return (s == AUX_SETUP) || (s == AUX_STROBE) || (s == AUX_DONE);
  endfunction

endpackage

// File: rtl/sram_arb_starve_ctr.sv
// Aux starvation counter: counts cycles the aux port waits outside an aux
// transfer and saturates at LIMIT. Built only with SRAM_ARB_STARVE_GUARD_EN.
module sram_arb_starve_ctr #(
  parameter int LIMIT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic count_en,
  input  logic clear,
  output logic starved
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt;

  // Saturating wait counter, cleared when the aux request is served or withdrawn.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (count_en && (cnt != W'(LIMIT))) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign starved = (cnt == W'(LIMIT));

endmodule

// File: rtl/sram_access_arbiter.sv
// Expansion SRAM arbiter: CPU accesses have absolute priority, aux
// block-transfer accesses fill idle windows and restart when preempted.
// Optional starvation guard: define SRAM_ARB_STARVE_GUARD_EN.
//
// Aux handshake: aux_req/aux_we/aux_adr/aux_wdata are held stable by the
// requester until aux_ack. aux_ack is a one-cycle pulse; aux_rdata is valid
// in that cycle. Dropping aux_req before aux_ack abandons the transfer with
// no ack. A preempted transfer issues no ack and restarts from AUX_SETUP.
module sram_access_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int AUX_CYCLES   = 2,
  parameter int STARVE_LIMIT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_adr,
  input  logic              aux_req,
  input  logic              aux_we,
  input  logic [ADDR_W-1:0] aux_adr,
  input  logic [7:0]        aux_wdata,
  output logic              aux_ack,
  output logic [7:0]        aux_rdata,
  input  logic [7:0]        sram_din,
  output logic [7:0]        sram_dout,
  output logic              sram_dout_en,
  output logic [ADDR_W-2:0] sram_adr,
  output logic              ramcs0_b,
  output logic              ramcs1_b,
  output logic              ramoe_b,
  output logic              ramwe_b,
  output logic              cpu_wait_b
);

  localparam int CNT_W = (AUX_CYCLES > 1) ? $clog2(AUX_CYCLES) : 1;

  if (AUX_CYCLES < 1 || STARVE_LIMIT < 1) begin : g_param_check
    $error("sram_access_arbiter: AUX_CYCLES and STARVE_LIMIT must be at least 1");
  end

  arb_state_e       state, state_nxt;
  logic [CNT_W-1:0] strobe_cnt;
  logic             last_strobe;
  logic             guard_active;
  logic             preempt;

  assign last_strobe = (strobe_cnt == '0);
  // While the guard holds the CPU off, the aux transfer may not be preempted.
  assign preempt     = cpu_req && !guard_active;
  assign sram_dout   = aux_wdata;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Strobe-length counter: held at full count outside AUX_STROBE, so each
  // entry into the strobe phase starts a fresh AUX_CYCLES window.
  always_ff @(posedge clk) begin
    if (reset || (state != AUX_STROBE)) strobe_cnt <= CNT_W'(AUX_CYCLES - 1);
    else if (!last_strobe)              strobe_cnt <= strobe_cnt - 1'b1;
  end

  // Capture read data on the last strobe cycle of an uninterrupted aux read.
  always_ff @(posedge clk) begin
    if (reset) begin
      aux_rdata <= '0;
    end else if ((state == AUX_STROBE) && last_strobe && !preempt && aux_req && !aux_we) begin
      aux_rdata <= sram_din;
    end
  end

  // Next-state logic and SRAM pin drive.
  always_comb begin
    state_nxt    = state;
    ramcs0_b     = 1'b1;
    ramcs1_b     = 1'b1;
    ramoe_b      = 1'b1;
    ramwe_b      = 1'b1;
    sram_dout_en = 1'b0;
    aux_ack      = 1'b0;
    sram_adr     = aux_adr[ADDR_W-2:0];
    unique case (state)
      IDLE: begin
        if (cpu_req && !guard_active) state_nxt = CPU;
        else if (aux_req)             state_nxt = AUX_SETUP;
      end
      CPU: begin
        sram_adr = cpu_adr[ADDR_W-2:0];
        if (cpu_req) begin
          ramcs0_b = cpu_adr[CHIP_SEL_BIT];
          ramcs1_b = !cpu_adr[CHIP_SEL_BIT];
          ramoe_b  = cpu_we;
          ramwe_b  = !cpu_we;
        end else begin
          state_nxt = IDLE;
        end
      end
      AUX_SETUP: begin
        ramcs0_b     = aux_adr[CHIP_SEL_BIT];
        ramcs1_b     = !aux_adr[CHIP_SEL_BIT];
        sram_dout_en = aux_we;
        if (preempt)       state_nxt = CPU;
        else if (!aux_req) state_nxt = IDLE;
        else               state_nxt = AUX_STROBE;
      end
      AUX_STROBE: begin
        ramcs0_b     = aux_adr[CHIP_SEL_BIT];
        ramcs1_b     = !aux_adr[CHIP_SEL_BIT];
        sram_dout_en = aux_we;
        // A CPU claim pulls the strobe immediately so the CPU cycle starts clean.
        if (!preempt) begin
          ramoe_b = aux_we;
          ramwe_b = !aux_we;
        end
        if (preempt)          state_nxt = CPU;
        else if (!aux_req)    state_nxt = IDLE;
        else if (last_strobe) state_nxt = AUX_DONE;
      end
      AUX_DONE: begin
        // Chip select and write data are held while the strobe is released.
        ramcs0_b     = aux_adr[CHIP_SEL_BIT];
        ramcs1_b     = !aux_adr[CHIP_SEL_BIT];
        sram_dout_en = aux_we;
        aux_ack      = 1'b1;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef SRAM_ARB_STARVE_GUARD_EN
  logic starved;
  logic hold;

  sram_arb_starve_ctr #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve_ctr (
    .clk      (clk),
    .reset    (reset),
    .count_en (aux_req && !is_aux_state(state)),
    .clear    (aux_ack || !aux_req),
    .starved  (starved)
  );

  // Guard latch: engages at the first IDLE cycle once starved, holds until ack.
  always_ff @(posedge clk) begin
    if (reset || aux_ack || !aux_req)   hold <= 1'b0;
    else if ((state == IDLE) && starved) hold <= 1'b1;
  end

  assign guard_active = aux_req && (hold || ((state == IDLE) && starved));
  assign cpu_wait_b   = !(guard_active && (state != CPU));
`else
  assign guard_active = 1'b0;
  assign cpu_wait_b   = 1'b1;
`endif

endmodule
